// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer: FSM encodings, note table and song lengths.
package beat_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Above the audible range, so the divide path produces silence.
    localparam int unsigned TONE_SIL = 20000;

    localparam int unsigned C4 = 262;
    localparam int unsigned D4 = 294;
    localparam int unsigned E4 = 330;
    localparam int unsigned F4 = 349;
    localparam int unsigned G4 = 392;
    localparam int unsigned A4 = 440;
    localparam int unsigned B4 = 494;
    localparam int unsigned C5 = 523;
    localparam int unsigned D5 = 587;
    localparam int unsigned E5 = 659;
    localparam int unsigned F5 = 698;
    localparam int unsigned G5 = 784;
    localparam int unsigned A5 = 880;
    localparam int unsigned B5 = 988;

    localparam int unsigned NUM_SONGS = 4;
    localparam int unsigned LAST_BEAT [NUM_SONGS] = '{1200, 63, 31, 15};

    // Songs beyond the table have a single beat.
    function automatic int unsigned last_beat_of(input int unsigned song);
        logic [1:0] idx;
        idx = song[1:0];
        return (song < NUM_SONGS) ? LAST_BEAT[idx] : 0;
    endfunction

    // C-major scale step 0..7, C4 up to C5.
    function automatic int unsigned scale_note(input logic [2:0] idx);
        int unsigned hz;
        case (idx)
            3'd0:    hz = C4;
            3'd1:    hz = D4;
            3'd2:    hz = E4;
            3'd3:    hz = F4;
            3'd4:    hz = G4;
            3'd5:    hz = A4;
            3'd6:    hz = B4;
            default: hz = C5;
        endcase
        return hz;
    endfunction

endpackage

// File: rtl/beat_sequencer_song_rom.sv
// Combinational song table: (song, beat) -> one tone word per channel, plus the song's last beat.
module song_rom
    import beat_seq_pkg::*;
#(
    parameter int unsigned BEAT_W = 12,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned TONE_W = 32,
    parameter int unsigned SONG_W = 2
) (
    input  logic [SONG_W-1:0]      song,
    input  logic [BEAT_W-1:0]      beat,
    output logic [N_CH*TONE_W-1:0] tone,
    output logic [BEAT_W-1:0]      last_beat
);

    // Every song closes on a C5/C4 chord; channels above 1 are always at rest.
    function automatic logic [TONE_W-1:0] entry(input logic [SONG_W-1:0] s,
                                                input logic [BEAT_W-1:0] b,
                                                input logic [BEAT_W-1:0] last,
                                                input int unsigned       c);
        int unsigned hz;
        hz = TONE_SIL;
        if (c >= 2) begin
            hz = TONE_SIL;
        end else if (b == last) begin
            hz = (c == 0) ? C5 : C4;
        end else begin
            case (32'(s))
                32'd0: begin
                    if (c == 0) hz = scale_note(b[2:0]);
                    else        hz = (b[1:0] == 2'd3) ? TONE_SIL : (b[3] ? G4 : C4);
                end
                32'd1: begin
                    if (c == 0) hz = scale_note(3'd7 - b[2:0]);
                    else        hz = E4;
                end
                32'd2: begin
                    if (c == 0) hz = b[0] ? E5 : C5;
                    else        hz = b[1] ? F5 : D5;
                end
                32'd3: begin
                    if (c == 0) hz = G5;
                    else        hz = b[1] ? B5 : A5;
                end
                default: hz = TONE_SIL;
            endcase
        end
        return TONE_W'(hz);
    endfunction

    always_comb begin
        last_beat = BEAT_W'(last_beat_of(32'(song)));
        tone      = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            tone[c*TONE_W +: TONE_W] = entry(song, beat, last_beat, c);
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// Play/pause/stop music sequencer: tempo prescaler, beat counter and registered per-channel tone words.
module beat_sequencer
    import beat_seq_pkg::*;
#(
    parameter int unsigned BEAT_W = 12,
    parameter int unsigned N_CH   = 2,
    parameter int unsigned TONE_W = 32,
    parameter int unsigned SONG_W = 2,
    parameter int unsigned DIV_W  = 4
) (
    input  logic                   clk22,
    input  logic                   rst,
    input  logic                   play,
    input  logic                   pause,
    input  logic                   stop,
    input  logic                   loop_en,
    input  logic [SONG_W-1:0]      song_sel,
    input  logic [DIV_W-1:0]       tempo_div,
    output logic [BEAT_W-1:0]      beat_num,
    output logic [N_CH*TONE_W-1:0] tone,
    output logic                   playing,
    output logic                   song_end,
    output logic [1:0]             state
);

    localparam int unsigned TONES_W = N_CH * TONE_W;
    localparam logic [TONES_W-1:0] SILENT = {N_CH{TONE_W'(TONE_SIL)}};

    seq_state_t          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d, last_beat;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic                play_q;
    logic                start_c;
    logic                song_end_d;
    logic [TONES_W-1:0]  rom_tone, tone_q;

    song_rom #(
        .BEAT_W (BEAT_W),
        .N_CH   (N_CH),
        .TONE_W (TONE_W),
        .SONG_W (SONG_W)
    ) u_song_rom (
        .song      (song_q),
        .beat      (beat_q),
        .tone      (rom_tone),
        .last_beat (last_beat)
    );

    assign start_c = play & ~play_q;

    // Next state; stop beats pause beats start beats the beat advance.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        presc_d    = presc_q;
        song_d     = song_q;
        song_end_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                beat_d  = '0;
                presc_d = '0;
                if (!stop && !pause && start_c) begin
                    state_d = ST_PLAY;
                    song_d  = song_sel;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    presc_d = '0;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (presc_q >= tempo_div) begin
                    presc_d = '0;
                    if (beat_q == last_beat) begin
                        song_end_d = 1'b1;
                        if (loop_en) beat_d  = '0;
                        else         state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    presc_d = '0;
                end else if (!pause) begin
                    state_d = ST_PLAY;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    presc_d = '0;
                end else if (!pause && start_c) begin
                    state_d = ST_PLAY;
                    beat_d  = '0;
                    presc_d = '0;
                    song_d  = song_sel;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tone is looked up from the current beat, so it trails beat_num by one cycle.
    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            presc_q  <= '0;
            song_q   <= '0;
            play_q   <= 1'b0;
            tone_q   <= SILENT;
            playing  <= 1'b0;
            song_end <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            presc_q  <= presc_d;
            song_q   <= song_d;
            play_q   <= play;
            tone_q   <= (state_q == ST_PLAY) ? rom_tone : SILENT;
            playing  <= (state_d == ST_PLAY);
            song_end <= song_end_d;
        end
    end

    assign beat_num = beat_q;
    assign tone     = tone_q;
    assign state    = state_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer: expected output events are queued by the stimulus and checked by a monitor.
module tb_beat_sequencer;

    localparam int SIL = 20000;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_PAUSE = 2, ST_DONE = 3;

    logic        clk22 = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [1:0]  song_sel = 2'd0;
    logic [3:0]  tempo_div = 4'd0;
    logic [11:0] beat_num;
    logic [63:0] tone;
    logic        playing, song_end;
    logic [1:0]  state;

    beat_sequencer dut (
        .clk22     (clk22),
        .rst       (rst),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .song_sel  (song_sel),
        .tempo_div (tempo_div),
        .beat_num  (beat_num),
        .tone      (tone),
        .playing   (playing),
        .song_end  (song_end),
        .state     (state)
    );

    always #5 clk22 = ~clk22;

    typedef struct {
        int st;
        int beat;
        int se;
        int gap;
        int song;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur_ev;
    int  total = 0;
    int  bad = 0;
    int  up_scale [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    // Hand-written song table: final beat is a C5/C4 chord, channels above 1 rest.
    function automatic int exp_tone(input int s, input int b, input int c);
        int lb;
        lb = (s == 0) ? 1200 : (s == 1) ? 63 : (s == 2) ? 31 : 15;
        if (c > 1) return SIL;
        if (b == lb) return (c == 0) ? 523 : 262;
        case (s)
            0: return (c == 0) ? up_scale[b % 8] : ((b % 4 == 3) ? SIL : (((b / 8) % 2 == 1) ? 392 : 262));
            1: return (c == 0) ? up_scale[7 - (b % 8)] : 330;
            2: return (c == 0) ? (((b % 2) == 1) ? 659 : 523) : ((((b / 2) % 2) == 1) ? 698 : 587);
            default: return (c == 0) ? 784 : ((((b / 2) % 2) == 1) ? 988 : 880);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input int st, input int b, input int se, input int gap, input int song);
        ev_t e;
        e.st = st; e.beat = b; e.se = se; e.gap = gap; e.song = song;
        exp_q.push_back(e);
    endtask

    // Monitor: any change of {state, beat_num, song_end} is an output event.
    int          since_ev = 0;
    logic        tone_pend = 1'b0;
    int          tone_exp [2];
    logic [14:0] prev_key = '0;

    always @(negedge clk22) begin
        if (rst) begin
            since_ev  = 0;
            tone_pend = 1'b0;
            prev_key  = '0;
        end else begin
            since_ev++;
            if (tone_pend) begin
                for (int c = 0; c < 2; c++)
                    chk($sformatf("tone_ch%0d", c), int'(tone[c*32 +: 32]), tone_exp[c]);
                tone_pend = 1'b0;
            end
            if ({state, beat_num, song_end} != prev_key) begin
                prev_key = {state, beat_num, song_end};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: state=%0d beat=%0d song_end=%0d, required no event",
                             state, beat_num, song_end);
                end else begin
                    cur_ev = exp_q.pop_front();
                    chk("event_state", int'(state), cur_ev.st);
                    chk("event_beat", int'(beat_num), cur_ev.beat);
                    chk("event_song_end", int'(song_end), cur_ev.se);
                    chk("event_playing", int'(playing), (cur_ev.st == ST_PLAY) ? 1 : 0);
                    if (cur_ev.gap >= 0) chk("event_gap", since_ev, cur_ev.gap);
                    for (int c = 0; c < 2; c++)
                        tone_exp[c] = (cur_ev.st == ST_PLAY) ? exp_tone(cur_ev.song, cur_ev.beat, c) : SIL;
                    tone_pend = 1'b1;
                end
                since_ev = 0;
            end
        end
    end

    task automatic pulse_play();
        play = 1'b1;
        @(negedge clk22);
        play = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(negedge clk22);
        stop = 1'b0;
    endtask

    task automatic wait_ev(input int st, input int b, input int se, input int budget);
        int n;
        n = 0;
        while (!(int'(state) == st && int'(beat_num) == b && int'(song_end) == se) && n < budget) begin
            @(negedge clk22);
            n++;
        end
        if (n >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_timeout: state=%0d beat=%0d, required state=%0d beat=%0d", state, beat_num, st, b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk22);
        rst = 1'b0;
        @(negedge clk22);
        chk("reset_state", int'(state), ST_IDLE);
        chk("reset_beat", int'(beat_num), 0);
        chk("reset_song_end", int'(song_end), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_tone0", int'(tone[31:0]), SIL);
        chk("reset_tone1", int'(tone[63:32]), SIL);

        // Song 0, tempo_div=3: one beat per 4 cycles
        tempo_div = 4'd3; song_sel = 2'd0; loop_en = 1'b1;
        push(ST_PLAY, 0, 0, -1, 0);
        for (int b = 1; b <= 6; b++) push(ST_PLAY, b, 0, 4, 0);
        push(ST_IDLE, 0, 0, 1, 0);
        pulse_play();
        wait_ev(ST_PLAY, 6, 0, 100);
        stop_pulse();
        repeat (3) @(negedge clk22);

        // Looping wrap 1200 -> 0 at full speed
        tempo_div = 4'd0;
        push(ST_PLAY, 0, 0, -1, 0);
        for (int b = 1; b <= 1200; b++) push(ST_PLAY, b, 0, 1, 0);
        push(ST_PLAY, 0, 1, 1, 0);
        push(ST_PLAY, 1, 0, 1, 0);
        push(ST_IDLE, 0, 0, 1, 0);
        pulse_play();
        wait_ev(ST_PLAY, 0, 1, 2000);
        @(negedge clk22);
        stop_pulse();
        repeat (3) @(negedge clk22);

        // One-shot end, then restart on song 1 from DONE
        loop_en = 1'b0;
        push(ST_PLAY, 0, 0, -1, 0);
        for (int b = 1; b <= 1200; b++) push(ST_PLAY, b, 0, 1, 0);
        push(ST_DONE, 1200, 1, 1, 0);
        push(ST_DONE, 1200, 0, 1, 0);
        pulse_play();
        wait_ev(ST_DONE, 1200, 0, 2000);
        repeat (2) @(negedge clk22);
        song_sel = 2'd1;
        push(ST_PLAY, 0, 0, -1, 1);
        push(ST_PLAY, 1, 0, 1, 1);
        push(ST_PLAY, 2, 0, 1, 1);
        push(ST_IDLE, 0, 0, 1, 1);
        pulse_play();
        wait_ev(ST_PLAY, 2, 0, 100);
        stop_pulse();
        repeat (3) @(negedge clk22);

        // Pause at beat 50 with presc=2 for 10 cycles, tempo_div=5
        tempo_div = 4'd5; song_sel = 2'd0; loop_en = 1'b1;
        push(ST_PLAY, 0, 0, -1, 0);
        for (int b = 1; b <= 50; b++) push(ST_PLAY, b, 0, 6, 0);
        push(ST_PAUSE, 50, 0, 3, 0);
        push(ST_PLAY, 50, 0, 10, 0);
        push(ST_PLAY, 51, 0, 4, 0);
        push(ST_IDLE, 0, 0, 1, 0);
        pulse_play();
        wait_ev(ST_PLAY, 50, 0, 1000);
        repeat (2) @(negedge clk22);
        pause = 1'b1;
        repeat (10) @(negedge clk22);
        pause = 1'b0;
        wait_ev(ST_PLAY, 51, 0, 100);

        // stop+pause together with play held high: IDLE, no restart
        stop = 1'b1; pause = 1'b1; play = 1'b1;
        @(negedge clk22);
        stop = 1'b0; pause = 1'b0;
        repeat (12) @(negedge clk22);
        chk("held_play_state", int'(state), ST_IDLE);
        chk("held_play_beat", int'(beat_num), 0);
        play = 1'b0;
        @(negedge clk22);
        push(ST_PLAY, 0, 0, -1, 0);
        push(ST_IDLE, 0, 0, 1, 0);
        play = 1'b1;
        wait_ev(ST_PLAY, 0, 0, 20);
        stop_pulse();
        play = 1'b0;
        repeat (5) @(negedge clk22);

        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Parametrised multi-channel music sequencer on the slow clk22 domain. It generalises the free-running beat counter into a play/pause/stop state machine. It adds song selection, a tempo prescaler, a loop/one-shot mode and an end-of-song pulse. It outputs one tone word (Hz) per channel into the existing frequency-divide and note-generation path.

## Interface
Parameters:
- BEAT_W, 12, beat index width.
- N_CH, 2, number of tone channels.
- TONE_W, 32, tone word width (Hz).
- SONG_W, 2, song select width (up to 4 songs).
- DIV_W, 4, tempo divider width.

Ports (reset rst, asynchronous, active-high; clock clk22):
- clk22, in, 1, sequencer clock.
- rst, in, 1, async active-high reset.
- play, in, 1, level input; internally rising-edge detected = start.
- pause, in, 1, level input; hold to pause.
- stop, in, 1, level input; forces IDLE.
- loop_en, in, 1, 1 = wrap at song end, 0 = one-shot.
- song_sel, in, SONG_W, song index; latched on start only.
- tempo_div, in, DIV_W, beat advances every tempo_div+1 clk22 cycles.
- beat_num, out, BEAT_W, current beat.
- tone, out, N_CH*TONE_W, channel c at [c*TONE_W +: TONE_W].
- playing, out, 1, high in PLAY.
- song_end, out, 1, one-cycle pulse at last-beat advance.
- state, out, 2, FSM state.

## Operation
- States: IDLE=0, PLAY=1, PAUSE=2, DONE=3.
- start = play & ~play_q; play_q is registered every cycle.
- Priority each cycle: stop > pause > start > beat advance.
- IDLE:
  - beat=0, presc=0, tones silent.
  - start: latch song_sel into cur_song, go to PLAY at beat 0.
- PLAY:
  - presc increments each cycle.
  - When presc >= tempo_div: presc clears and the beat advances. The >= compare means shrinking tempo_div mid-song advances the beat on the next cycle.
  - Advance while beat_num == last_beat(cur_song):
    - loop_en=1: beat_num becomes 0, song_end pulses, stay in PLAY.
    - loop_en=0: beat_num holds last_beat, song_end pulses, go to DONE.
  - pause=1: go to PAUSE; beat and presc freeze.
  - stop: go to IDLE.
  - start in PLAY is ignored.
- PAUSE:
  - Tones silent.
  - pause=0: return to PLAY, resuming with beat and presc unchanged.
  - stop: go to IDLE.
- DONE:
  - Tones silent; beat holds.
  - start: re-latch song_sel, go to PLAY at beat 0, presc 0.
  - stop: go to IDLE.
- Tone output:
  - Registered. tone_c = song_rom(cur_song, beat_num, c) in PLAY, TONE_SIL otherwise.
  - A ROM entry of TONE_SIL means a rest.
- Arithmetic: beat and presc are unsigned and never exceed last_beat / tempo_div. last_beat < 2^BEAT_W.

## Timing
- Reset values:
  - state=IDLE, beat_num=0, presc=0, cur_song=0, play_q=0.
  - tone=all TONE_SIL, playing=0, song_end=0.
- Reset mid-song: immediate return to IDLE. play still high at release counts as a start on the first clocked cycle.
- State, beat_num, playing and song_end update on the same clk22 edge.
- tone lags beat_num by exactly one clk22 cycle.
- tone returns to TONE_SIL one cycle after leaving PLAY.
- With tempo_div=0, beat advances every cycle. Loop wrap L→0 costs one beat with no gap.
- stop and pause asserted together: stop wins.

## Structure
- Package beat_seq_pkg holds:
  - state encodings;
  - TONE_SIL = 20000 (inaudible);
  - note constants in Hz (C4=262 … B5=988);
  - per-song LAST_BEAT array, song 0 = 1200.
- Sub-module song_rom: combinational (song, beat, ch) → tone, plus last_beat(song). Song contents are edited there only.
- The sequencer FSM, prescaler and output registers live in beat_sequencer.

## Test plan
- Reset with play=0 → state=0, beat_num=0, tone=TONE_SIL on every channel, song_end=0.
- tempo_div=3, song 0, play pulse → beat_num increments every 4 clk22 cycles. tone[0] equals ROM(0, beat, 0) one cycle after each beat change.
- loop_en=1, song 0 (last_beat 1200), tempo_div=0 → beat_num sequence 1199, 1200, 0, 1. song_end is high for exactly one cycle on the 1200→0 edge. playing stays 1.
- loop_en=0, same setup → beat_num holds at 1200, state=3, one song_end pulse, tones silent after one cycle. New play edge with song_sel=1 → beat 0, cur_song=1.
- pause asserted at beat 50 with presc=2 for 10 cycles → beat and presc frozen, tones silent. On release, the next beat change occurs after exactly tempo_div−2+1 cycles.
- stop+pause asserted together in PLAY → IDLE next cycle, beat_num=0. Holding play high throughout does not restart; only a fresh play edge does.
